// File: rtl/turret_pkg.sv
// -----------------------------------------------------------------------------
// turret_pkg
// Shared definitions for the turret command arbiter:
//   - motion / fire servo code constants consumed by the PWM generators
//   - owner FSM and fire sequencer state enumerations
//   - sanitize_motion(): maps any unsupported motion code to CODE_STOP
// -----------------------------------------------------------------------------
package turret_pkg;

    localparam logic [3:0] CODE_HOLD = 4'd0;
    localparam logic [3:0] CODE_NEG  = 4'd1;
    localparam logic [3:0] CODE_POS  = 4'd2;
    localparam logic [3:0] CODE_STOP = 4'd5;

    typedef enum logic [1:0] {
        OWN_MAN     = 2'd0,
        GAP_TO_AUTO = 2'd1,
        OWN_AUTO    = 2'd2,
        GAP_TO_MAN  = 2'd3
    } owner_state_t;

    // Encodings equal the fire servo codes, so the state register drives
    // the fire code output directly.
    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_FIRE   = 2'd1,
        F_RECOIL = 2'd2
    } fire_state_t;

    function automatic logic [3:0] sanitize_motion(input logic [3:0] code);
        case (code)
            CODE_HOLD, CODE_NEG, CODE_POS, CODE_STOP: return code;
            default:                                  return CODE_STOP;
        endcase
    endfunction

endpackage

// File: rtl/fire_sequencer.sv
// -----------------------------------------------------------------------------
// fire_sequencer
// Rising-edge detection of the fire requests and the fire/recoil timing FSM.
//   i_Clk, i_Rst       clock, asynchronous active-high reset
//   man_fire           manual fire request (level)
//   auto_fire          automatic fire request (level)
//   sel_auto           1 = automatic source owns the channel
//   enable             1 = a new trigger may be accepted (owner in an OWN state,
//                      no ownership change pending)
//   fire_code          registered fire servo code (0 idle, 1 fire, 2 recoil)
//   active             sequencer is not idle (registered)
//   active_next        sequencer will not be idle after the next edge
// -----------------------------------------------------------------------------
module fire_sequencer
    import turret_pkg::*;
#(
    parameter int unsigned FIRE_TICKS   = 22727272,
    parameter int unsigned RECOIL_TICKS = 22727272,
    parameter int unsigned CNT_W        = 25
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       man_fire,
    input  logic       auto_fire,
    input  logic       sel_auto,
    input  logic       enable,
    output logic [3:0] fire_code,
    output logic       active,
    output logic       active_next
);

    localparam logic [CNT_W-1:0] FIRE_LOAD   = CNT_W'(FIRE_TICKS - 1);
    localparam logic [CNT_W-1:0] RECOIL_LOAD = CNT_W'(RECOIL_TICKS - 1);

    fire_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             man_prev_q, auto_prev_q;
    logic             fire_edge;
    logic             trigger;

    // Each source has its own history, so a press made while a source does
    // not own the channel is consumed and never surfaces as an edge later.
    assign fire_edge = sel_auto ? (auto_fire & ~auto_prev_q)
                                : (man_fire  & ~man_prev_q);
    assign trigger   = fire_edge & enable & (state_q == F_IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            F_IDLE: begin
                if (trigger) begin
                    state_d = F_FIRE;
                    cnt_d   = FIRE_LOAD;
                end
            end
            F_FIRE: begin
                if (cnt_q == '0) begin
                    state_d = F_RECOIL;
                    cnt_d   = RECOIL_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            F_RECOIL: begin
                if (cnt_q == '0) begin
                    state_d = F_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = F_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= F_IDLE;
            cnt_q       <= '0;
            // History resets high: a request held through reset must be
            // released before it can fire.
            man_prev_q  <= 1'b1;
            auto_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            man_prev_q  <= man_fire;
            auto_prev_q <= auto_fire;
        end
    end

    assign fire_code   = {2'b00, state_q};
    assign active      = (state_q != F_IDLE);
    assign active_next = (state_d != F_IDLE);

endmodule

// File: rtl/turret_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// turret_cmd_arbiter
// Arbitrates the turret servo command channel between the manual and the
// automatic source, inserts a neutral gap on ownership changes and runs the
// fire/recoil sequence with a motion interlock.
//   i_Clk, i_Rst             clock, asynchronous active-high reset
//   i_Mode_Auto              1 = automatic source requested
//   i_Man_X/Y, i_Man_Fire    manual motion codes and fire request
//   i_Auto_X/Y, i_Auto_Fire  automatic motion codes and fire request
//   o_X_Code, o_Y_Code       registered motion codes to the PWM blocks
//   o_Fire_Code              registered fire servo code
//   o_Owner                  0 = manual owns, 1 = automatic owns
//   o_Busy                   gap or fire sequence in progress
// -----------------------------------------------------------------------------
module turret_cmd_arbiter
    import turret_pkg::*;
#(
    parameter int unsigned FIRE_TICKS   = 22727272,
    parameter int unsigned RECOIL_TICKS = 22727272,
    parameter int unsigned SWITCH_GAP   = 1000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Mode_Auto,
    input  logic [3:0] i_Man_X,
    input  logic [3:0] i_Man_Y,
    input  logic       i_Man_Fire,
    input  logic [3:0] i_Auto_X,
    input  logic [3:0] i_Auto_Y,
    input  logic       i_Auto_Fire,
    output logic [3:0] o_X_Code,
    output logic [3:0] o_Y_Code,
    output logic [3:0] o_Fire_Code,
    output logic       o_Owner,
    output logic       o_Busy
);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(SWITCH_GAP - 1);

    owner_state_t     owner_q, owner_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             switch_req;
    logic             fire_enable;
    logic             fire_active, fire_active_next;
    logic             gap_next;
    logic             neutral_next;

    fire_sequencer #(
        .FIRE_TICKS   (FIRE_TICKS),
        .RECOIL_TICKS (RECOIL_TICKS),
        .CNT_W        (CNT_W)
    ) u_fire_sequencer (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .man_fire    (i_Man_Fire),
        .auto_fire   (i_Auto_Fire),
        .sel_auto    (owner_q == OWN_AUTO),
        .enable      (fire_enable),
        .fire_code   (o_Fire_Code),
        .active      (fire_active),
        .active_next (fire_active_next)
    );

    always_comb begin
        owner_d    = owner_q;
        gap_cnt_d  = gap_cnt_q;
        switch_req = 1'b0;
        case (owner_q)
            OWN_MAN: begin
                if (i_Mode_Auto) begin
                    switch_req = 1'b1;
                    // An ownership change waits for the sequencer to go idle.
                    if (!fire_active) begin
                        owner_d   = GAP_TO_AUTO;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            OWN_AUTO: begin
                if (!i_Mode_Auto) begin
                    switch_req = 1'b1;
                    if (!fire_active) begin
                        owner_d   = GAP_TO_MAN;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            GAP_TO_AUTO: begin
                if (!i_Mode_Auto) begin
                    owner_d   = GAP_TO_MAN;
                    gap_cnt_d = GAP_LOAD;
                end else if (gap_cnt_q == '0) begin
                    owner_d = OWN_AUTO;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            GAP_TO_MAN: begin
                if (i_Mode_Auto) begin
                    owner_d   = GAP_TO_AUTO;
                    gap_cnt_d = GAP_LOAD;
                end else if (gap_cnt_q == '0) begin
                    owner_d = OWN_MAN;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                owner_d   = OWN_MAN;
                gap_cnt_d = '0;
            end
        endcase
    end

    // A trigger in the same cycle as an ownership request would race the
    // gap; the request wins and the press is dropped like any gap press.
    assign fire_enable  = ((owner_q == OWN_MAN) || (owner_q == OWN_AUTO)) && !switch_req;
    assign gap_next     = (owner_d == GAP_TO_AUTO) || (owner_d == GAP_TO_MAN);
    assign neutral_next = gap_next || fire_active_next;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            owner_q   <= OWN_MAN;
            gap_cnt_q <= '0;
        end else begin
            owner_q   <= owner_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Outputs are registered from next-state values so they line up with the
    // state they describe, one cycle after the inputs are sampled.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_X_Code <= CODE_HOLD;
            o_Y_Code <= CODE_HOLD;
            o_Owner  <= 1'b0;
            o_Busy   <= 1'b0;
        end else begin
            if (owner_d == OWN_AUTO) begin
                o_Owner <= 1'b1;
            end else if (owner_d == OWN_MAN) begin
                o_Owner <= 1'b0;
            end
            o_Busy <= neutral_next;
            if (neutral_next) begin
                o_X_Code <= CODE_STOP;
                o_Y_Code <= CODE_STOP;
            end else if (owner_d == OWN_AUTO) begin
                o_X_Code <= sanitize_motion(i_Auto_X);
                o_Y_Code <= sanitize_motion(i_Auto_Y);
            end else begin
                o_X_Code <= sanitize_motion(i_Man_X);
                o_Y_Code <= sanitize_motion(i_Man_Y);
            end
        end
    end

endmodule
